// File: rtl/roe_run_sequencer.sv
// ---------------------------------------------------------------------------
// roe_run_sequencer
//   Req/ack run controller for the ROE program core. After a start strobe it
//   walks the latched program mask from the lowest set bit upward. For each
//   slot it raises req for REQ_CYCLES cycles, waits for a rising edge on ack,
//   reports the run length in cycles, and moves on to the next slot. A
//   watchdog aborts the whole sequence if a slot does not answer within
//   TIMEOUT cycles of its req rising.
//
// Ports
//   clk          clock, all state on the rising edge
//   reset        asynchronous reset, active low
//   start        1-cycle strobe, accepted only in IDLE
//   abort        return to IDLE from any busy state, no completion pulses
//   prog_mask    slots to run, sampled when start is accepted
//   ack          level "done" indication from the core
//   req          launch request to the core
//   prog_sel     slot currently launched or running
//   busy         high whenever the sequencer is not IDLE
//   run_done     1-cycle pulse, slot prog_sel completed
//   run_cycles   cycles from req rise to ack rise, held until the next run
//   seq_done     1-cycle pulse, every masked slot completed
//   timeout_err  sticky watchdog flag, cleared by the next accepted start
// ---------------------------------------------------------------------------
module roe_run_sequencer #(
    parameter int NUM_PROGS  = 4,
    parameter int CNT_W      = 16,
    parameter int REQ_CYCLES = 1,
    parameter int TIMEOUT    = 1000,
    localparam int SEL_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_PROGS-1:0] prog_mask,
    input  logic                 ack,
    output logic                 req,
    output logic [SEL_W-1:0]     prog_sel,
    output logic                 busy,
    output logic                 run_done,
    output logic [CNT_W-1:0]     run_cycles,
    output logic                 seq_done,
    output logic                 timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        REQ,
        WAIT,
        REPORT,
        FINISH
    } state_t;

    state_t               state, state_n;
    logic [NUM_PROGS-1:0] mask, mask_n;
    logic [CNT_W-1:0]     cnt, cnt_n, cnt_inc;
    logic                 ack_q;
    logic                 ack_edge;
    logic [SEL_W-1:0]     low_idx;
    logic [SEL_W-1:0]     sel_n;
    logic                 req_n, run_done_n, seq_done_n, timeout_n;
    logic [CNT_W-1:0]     run_cycles_n;

    // Only a fresh rising edge completes a run; an ack left high by a
    // previous run never counts.
    assign ack_edge = ack & ~ack_q;

    // Counter saturates instead of wrapping so an extremely long run still
    // reports the largest representable length.
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

    // Lowest set bit of the remaining mask; scanning downward lets the
    // lowest index win.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_PROGS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_n      = state;
        mask_n       = mask;
        sel_n        = prog_sel;
        cnt_n        = cnt;
        req_n        = 1'b0;
        run_done_n   = 1'b0;
        seq_done_n   = 1'b0;
        run_cycles_n = run_cycles;
        timeout_n    = timeout_err;

        case (state)
            IDLE: begin
                if (start) begin
                    mask_n    = prog_mask;
                    timeout_n = 1'b0;
                    state_n   = SELECT;
                end
            end
            SELECT: begin
                if (mask == '0) begin
                    seq_done_n = 1'b1;
                    state_n    = FINISH;
                end else begin
                    sel_n   = low_idx;
                    // x & (x-1) clears the lowest set bit
                    mask_n  = mask & (mask - 1'b1);
                    cnt_n   = '0;
                    req_n   = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                cnt_n = cnt_inc;
                // cnt started at 0 on entry, so it doubles as the req-width counter
                if (cnt >= CNT_W'(REQ_CYCLES - 1)) begin
                    state_n = WAIT;
                end else begin
                    req_n = 1'b1;
                end
            end
            WAIT: begin
                cnt_n = cnt_inc;
                if (ack_edge) begin
                    run_cycles_n = cnt;
                    run_done_n   = 1'b1;
                    state_n      = REPORT;
                end else if (cnt >= CNT_W'(TIMEOUT)) begin
                    timeout_n = 1'b1;
                    mask_n    = '0;
                    state_n   = IDLE;
                end
            end
            REPORT: begin
                state_n = SELECT;
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // abort overrides whatever the state logic decided this cycle
        if (abort && (state != IDLE)) begin
            state_n      = IDLE;
            mask_n       = '0;
            req_n        = 1'b0;
            run_done_n   = 1'b0;
            seq_done_n   = 1'b0;
            run_cycles_n = run_cycles;
            timeout_n    = timeout_err;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mask        <= '0;
            cnt         <= '0;
            ack_q       <= 1'b0;
            req         <= 1'b0;
            prog_sel    <= '0;
            busy        <= 1'b0;
            run_done    <= 1'b0;
            run_cycles  <= '0;
            seq_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            mask        <= mask_n;
            cnt         <= cnt_n;
            ack_q       <= ack;
            req         <= req_n;
            prog_sel    <= sel_n;
            busy        <= (state_n != IDLE);
            run_done    <= run_done_n;
            run_cycles  <= run_cycles_n;
            seq_done    <= seq_done_n;
            timeout_err <= timeout_n;
        end
    end

endmodule
